counter: RTL and testbench



---
 rtl/counter_pkg.sv | 29 ++
 rtl/counter_sat8.sv | 26 ++
 rtl/counter.sv | 78 +++++++
 tb/tb_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and the modulo-increment helper for the counter family.
// The overflow event counter is only built when COUNTER_OVF_CNT_EN is defined.
package counter_pkg;

    localparam int COUNTER_DEF_WIDTH = 4;
    localparam int COUNTER_OVF_W     = 8;

    typedef struct packed {
        logic [31:0] next;
        logic        wrapped;
    } mod_inc_t;

    // Operands are widened to 32 bits so one helper serves every WIDTH up to 32.
    // The sum is taken one bit wider so value+step never aliases.
    function automatic mod_inc_t mod_inc(
        input logic [31:0] value,
        input logic [31:0] step,
        input logic [31:0] max
    );
        logic [32:0] sum;
        mod_inc_t    r;
        sum       = {1'b0, value} + {1'b0, step};
        r.wrapped = (sum > {1'b0, max});
        // The reduced value is always below 2**32, so the low 32 bits are exact.
        r.next    = r.wrapped ? (sum[31:0] - max - 32'd1) : sum[31:0];
        return r;
    endfunction

endpackage

// File: rtl/counter_sat8.sv
// Saturating event counter: counts inc pulses, sticks at all-ones and
// clears on the synchronous active-low reset.
module counter_sat8
    import counter_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     inc,
    output logic [COUNTER_OVF_W-1:0] cnt
);

    localparam logic [COUNTER_OVF_W-1:0] CNT_MAX = '1;

    logic [COUNTER_OVF_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + COUNTER_OVF_W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/counter.sv
// Free-running modulo up-counter with terminal-count flag and registered wrap pulse.
// Define COUNTER_OVF_CNT_EN to add the 8-bit saturating ovf_cnt output.
module counter
    import counter_pkg::*;
#(
    parameter int                WIDTH     = COUNTER_DEF_WIDTH,
    parameter longint unsigned   MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter longint unsigned   STEP      = 1,
    parameter longint unsigned   RESET_VAL = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    output logic [WIDTH-1:0]         out,
    output logic                     tc,
    output logic                     wrap
`ifdef COUNTER_OVF_CNT_EN
    ,
    output logic [COUNTER_OVF_W-1:0] ovf_cnt
`endif
);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("counter: WIDTH=%0d outside 1..32", WIDTH);
    end
    if ((MAX_VAL < 64'd1) || (MAX_VAL >= (64'd1 << WIDTH))) begin : g_bad_max
        $error("counter: MAX_VAL=%0d does not fit WIDTH=%0d", MAX_VAL, WIDTH);
    end
    if ((STEP == 64'd0) || (STEP > MAX_VAL)) begin : g_bad_step
        $error("counter: STEP=%0d outside 1..MAX_VAL", STEP);
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("counter: RESET_VAL=%0d exceeds MAX_VAL", RESET_VAL);
    end

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] out_next;
    logic             wrap_reg;
    logic             wrap_next;
    mod_inc_t         inc;
    logic             unused_inc_hi;

    always_comb begin
        inc       = mod_inc(32'(out_reg), 32'(STEP), 32'(MAX_VAL));
        out_next  = inc.next[WIDTH-1:0];
        wrap_next = inc.wrapped;
    end

    // Upper helper bits are zero whenever WIDTH < 32.
    assign unused_inc_hi = ^inc.next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_reg  <= RST_W;
            wrap_reg <= 1'b0;
        end else begin
            out_reg  <= out_next;
            wrap_reg <= wrap_next;
        end
    end

    assign out  = out_reg;
    assign wrap = wrap_reg;
    assign tc   = (out_reg == MAX_W);

`ifdef COUNTER_OVF_CNT_EN
    // Fed with wrap_next so the count moves on the same edge that sets wrap.
    counter_sat8 u_ovf (
        .clk  (clk),
        .rstn (rstn),
        .inc  (wrap_next),
        .cnt  (ovf_cnt)
    );
`endif

endmodule

// File: tb/tb_counter.sv
// Random-reset bench for counter: several parameterisations run side by side
// against an arithmetic reference model.
module tb_counter;

    localparam int N = 5;
    localparam longint unsigned MAXV [N] = '{64'd15, 64'd9, 64'd15, 64'd200, 64'hFFFF_FFFF};
    localparam longint unsigned STEPV[N] = '{64'd1, 64'd3, 64'd1, 64'd7, 64'h9E37_79B9};
    localparam longint unsigned RSTV [N] = '{64'd0, 64'd0, 64'd5, 64'd13, 64'hFFFF_FFF0};

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic        rstn     [N];
    logic [31:0] obs_out  [N];
    logic        obs_tc   [N];
    logic        obs_wrap [N];
    logic [3:0]  out0;
    logic [3:0]  out1;
    logic [3:0]  out2;
    logic [7:0]  out3;
    logic [31:0] out4;
`ifdef COUNTER_OVF_CNT_EN
    logic [7:0]  obs_ovf  [N];
`endif

    counter u_def (
        .clk(clk), .rstn(rstn[0]), .out(out0), .tc(obs_tc[0]), .wrap(obs_wrap[0])
`ifdef COUNTER_OVF_CNT_EN
        , .ovf_cnt(obs_ovf[0])
`endif
    );
    counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .RESET_VAL(0)) u_m9 (
        .clk(clk), .rstn(rstn[1]), .out(out1), .tc(obs_tc[1]), .wrap(obs_wrap[1])
`ifdef COUNTER_OVF_CNT_EN
        , .ovf_cnt(obs_ovf[1])
`endif
    );
    counter #(.RESET_VAL(5)) u_r5 (
        .clk(clk), .rstn(rstn[2]), .out(out2), .tc(obs_tc[2]), .wrap(obs_wrap[2])
`ifdef COUNTER_OVF_CNT_EN
        , .ovf_cnt(obs_ovf[2])
`endif
    );
    counter #(.WIDTH(8), .MAX_VAL(200), .STEP(7), .RESET_VAL(13)) u_w8 (
        .clk(clk), .rstn(rstn[3]), .out(out3), .tc(obs_tc[3]), .wrap(obs_wrap[3])
`ifdef COUNTER_OVF_CNT_EN
        , .ovf_cnt(obs_ovf[3])
`endif
    );
    counter #(.WIDTH(32), .STEP(64'h9E37_79B9), .RESET_VAL(64'hFFFF_FFF0)) u_w32 (
        .clk(clk), .rstn(rstn[4]), .out(out4), .tc(obs_tc[4]), .wrap(obs_wrap[4])
`ifdef COUNTER_OVF_CNT_EN
        , .ovf_cnt(obs_ovf[4])
`endif
    );

    assign obs_out[0] = 32'(out0);
    assign obs_out[1] = 32'(out1);
    assign obs_out[2] = 32'(out2);
    assign obs_out[3] = 32'(out3);
    assign obs_out[4] = out4;

    // Reference model state
    longint unsigned e_out  [N];
    bit              e_wrap [N];
    bit              known  [N];
    int              e_ovf  [N];

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge: advance the model, then compare on the falling edge.
    task automatic step();
        longint unsigned s;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rstn[i]) begin
                e_out[i]  = RSTV[i];
                e_wrap[i] = 1'b0;
                e_ovf[i]  = 0;
                known[i]  = 1'b1;
            end else if (known[i]) begin
                s         = e_out[i] + STEPV[i];
                e_wrap[i] = (s > MAXV[i]);
                e_out[i]  = s % (MAXV[i] + 64'd1);
                if (e_wrap[i] && e_ovf[i] < 255) e_ovf[i]++;
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (known[i]) begin
                check($sformatf("u%0d.out", i), 64'(obs_out[i]), e_out[i]);
                check($sformatf("u%0d.wrap", i), 64'(obs_wrap[i]), 64'(e_wrap[i]));
                check($sformatf("u%0d.tc", i), 64'(obs_tc[i]), 64'(e_out[i] == MAXV[i]));
`ifdef COUNTER_OVF_CNT_EN
                check($sformatf("u%0d.ovf", i), 64'(obs_ovf[i]), 64'(e_ovf[i]));
`endif
            end
        end
        $display("edge: rstn=%b%b%b%b%b out=%0h,%0h,%0h,%0h,%0h vectors=%0d",
                 rstn[0], rstn[1], rstn[2], rstn[3], rstn[4],
                 obs_out[0], obs_out[1], obs_out[2], obs_out[3], obs_out[4], vectors);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rstn[i]  = 1'b1;
            known[i] = 1'b0;
            e_out[i] = 0;
            e_wrap[i] = 1'b0;
            e_ovf[i] = 0;
        end
        step();

        // Reset held for four edges
        for (int i = 0; i < N; i++) rstn[i] = 1'b0;
        repeat (4) step();

        // Free run through a full wrap on the default instance
        for (int i = 0; i < N; i++) rstn[i] = 1'b1;
        repeat (17) step();

        // Reset applied while the RESET_VAL=5 instance sits at its maximum
        for (int k = 0; k < 32 && e_out[2] != 64'd15; k++) step();
        check("r5.at_max", 64'(obs_out[2]), 64'd15);
        rstn[2] = 1'b0;
        step();
        rstn[2] = 1'b1;
        step();

        // Random reset pattern on every instance
        repeat (3000) begin
            for (int i = 0; i < N; i++) rstn[i] = ($urandom_range(0, 19) != 0);
            step();
        end

`ifdef COUNTER_OVF_CNT_EN
        for (int i = 0; i < N; i++) rstn[i] = 1'b0;
        step();
        for (int i = 0; i < N; i++) rstn[i] = 1'b1;
        repeat (16 * 260) step();
        check("def.ovf_sat", 64'(obs_ovf[0]), 64'd255);
        for (int i = 0; i < N; i++) rstn[i] = 1'b0;
        step();
        check("def.ovf_clr", 64'(obs_ovf[0]), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
